// File: rtl/axil_sa_loader_pkg.sv
// Shared definitions for the systolic-array operand loader.
// Holds the AXI4-Lite register byte offsets, the AXI response codes and the
// streaming FSM state type.
package axil_sa_loader_pkg;

  // Register byte offsets inside the 16-byte window
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_DATA   = 4'h8;
  localparam logic [3:0] ADDR_LEN    = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    DONE_ST = 2'd2
  } loader_state_t;

endpackage

// File: rtl/sa_sync_fifo.sv
// Single-clock operand FIFO.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           synchronous flush, wins over push/pop
//   push_i, wdata_i   write request and data; accepted when not full, or when
//                     a pop happens in the same cycle
//   pop_i             read request; ignored when empty
//   rdata_o           current head entry
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
module sa_sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot the push needs, so full does not block it
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are log2(Depth) wide, so they wrap modulo Depth for free
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/axil_sa_operand_loader.sv
// AXI4-Lite operand loader for the systolic array.
// Software pushes words through DATA, programs LEN, then sets CTRL.START; the
// block streams LEN words from its FIFO on the M_OP valid/ready interface,
// flagging the final word with M_OP_TLAST.
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*        AXI4-Lite write channels (AWPROT ignored)
//   S_AXI_AR*/R*           AXI4-Lite read channels (ARPROT ignored)
//   M_OP_TDATA/TVALID/TREADY/TLAST  operand stream to the array
//   IRQ                    done interrupt, only when SA_LOADER_IRQ_EN is defined
// Registers: 0x0 CTRL (W: bit0 START, bit1 CLEAR, bit2 IRQ_ENABLE with IRQ),
//   0x4 STATUS (R: BUSY, DONE, FULL, EMPTY, [15:8] count), 0x8 DATA (W),
//   0xC LEN (R/W, [7:0]).
module axil_sa_operand_loader
  import axil_sa_loader_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH         = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
`ifdef SA_LOADER_IRQ_EN
  output logic                          IRQ,
`endif
  output logic [C_S_AXI_DATA_WIDTH-1:0] M_OP_TDATA,
  output logic                          M_OP_TVALID,
  input  logic                          M_OP_TREADY,
  output logic                          M_OP_TLAST
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] WordCtrl   = ADDR_CTRL[3:2];
  localparam logic [1:0] WordStatus = ADDR_STATUS[3:2];
  localparam logic [1:0] WordData   = ADDR_DATA[3:2];
  localparam logic [1:0] WordLen    = ADDR_LEN[3:2];

  logic                          awready_q, awready_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  loader_state_t                 state_q, state_d;
  logic [7:0]                    len_q, len_d;
  logic [7:0]                    rem_q, rem_d;
  logic                          done_q, done_d;

  logic                          wr_hs, rd_hs;
  logic [1:0]                    wr_word, rd_word;
  logic                          ctrl_wr, start_evt, clear_evt, data_wr, slverr;
  logic                          pop, tvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] fifo_head;
  logic                          fifo_full, fifo_empty;
  logic [CntW-1:0]               fifo_count;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
  logic                          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Write-side decode
  // ---------------------------------------------------------------------------
  assign wr_hs     = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign wr_word   = S_AXI_AWADDR[3:2];
  assign ctrl_wr   = wr_hs & (wr_word == WordCtrl);
  assign start_evt = ctrl_wr & S_AXI_WDATA[0];
  assign clear_evt = ctrl_wr & S_AXI_WDATA[1];
  assign data_wr   = wr_hs & (wr_word == WordData) & (|S_AXI_WSTRB);

  // A word on the bus during CLEAR is discarded, not transferred
  assign tvalid = (state_q == STREAM) & ~fifo_empty;
  assign pop    = tvalid & M_OP_TREADY & ~clear_evt;
  assign slverr = data_wr & fifo_full & ~pop;

  sa_sync_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (C_S_AXI_DATA_WIDTH)
  ) u_fifo (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .clear_i (clear_evt),
    .push_i  (data_wr),
    .wdata_i (S_AXI_WDATA),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // AXI handshakes
  // ---------------------------------------------------------------------------
  always_comb begin
    // One-cycle ready pulse; the !ready term stops a second accept of the
    // same beat before BVALID has risen
    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = slverr ? RESP_SLVERR : RESP_OKAY;
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  assign rd_hs   = arready_q & S_AXI_ARVALID;
  assign rd_word = S_AXI_ARADDR[3:2];

  always_comb begin
    rd_mux = '0;
    case (rd_word)
      WordCtrl: begin
`ifdef SA_LOADER_IRQ_EN
        rd_mux[2] = irq_en_q;
`endif
      end
      WordStatus: begin
        rd_mux[0]    = (state_q != IDLE);
        rd_mux[1]    = done_q;
        rd_mux[2]    = fifo_full;
        rd_mux[3]    = fifo_empty;
        rd_mux[15:8] = 8'(fifo_count);
      end
      WordLen:  rd_mux[7:0] = len_q;
      WordData: rd_mux = '0;
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Streaming FSM and registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = done_q;
    len_d   = len_q;

    if (wr_hs && (wr_word == WordLen) && S_AXI_WSTRB[0]) begin
      len_d = S_AXI_WDATA[7:0];
    end

    case (state_q)
      IDLE: begin
        if (start_evt && (len_q != 8'd0) && (32'(fifo_count) >= 32'(len_q))) begin
          state_d = STREAM;
          rem_d   = len_q;
          done_d  = 1'b0;
        end
      end
      STREAM: begin
        if (pop) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = DONE_ST;
        end
      end
      DONE_ST: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clear_evt) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      state_q   <= IDLE;
      len_q     <= 8'd0;
      rem_q     <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      state_q   <= state_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
    end
  end

`ifdef SA_LOADER_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_flag_q, irq_flag_d;

  always_comb begin
    irq_en_d   = irq_en_q;
    irq_flag_d = irq_flag_q;
    if (ctrl_wr) irq_en_d = S_AXI_WDATA[2];
    if (state_q == DONE_ST) irq_flag_d = 1'b1;
    // Any START or CLEAR acknowledges the interrupt
    if (start_evt || clear_evt) irq_flag_d = 1'b0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_en_q   <= 1'b0;
      irq_flag_q <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  assign IRQ = irq_flag_q & irq_en_q;
`endif

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

  // TDATA is forced to zero outside a valid beat so reset reads back clean
  assign M_OP_TVALID = tvalid;
  assign M_OP_TDATA  = tvalid ? fifo_head : '0;
  assign M_OP_TLAST  = tvalid & (rem_q == 8'd1);

endmodule

// File: tb/tb_axil_sa_operand_loader.sv
// Scoreboard bench for axil_sa_operand_loader: stimulus pushes expected B
// responses, read data and stream beats into queues; a negedge monitor pops
// and compares whenever the DUT presents BVALID, RVALID or TVALID.
module tb_axil_sa_operand_loader;
  import axil_sa_loader_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
`ifdef SA_LOADER_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  logic allow_drop = 1'b0;
  logic prev_stall = 1'b0;

  logic [1:0]  exp_b[$];
  logic [31:0] exp_r[$];
  beat_t       exp_s[$];

  always #5 clk = ~clk;

  axil_sa_operand_loader dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
`ifdef SA_LOADER_IRQ_EN
    .IRQ           (irq),
`endif
    .M_OP_TDATA    (tdata),
    .M_OP_TVALID   (tvalid),
    .M_OP_TREADY   (tready),
    .M_OP_TLAST    (tlast)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid) begin
        check("b_pending", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) check("bresp", 32'(bresp), 32'(exp_b.pop_front()));
      end
      if (rvalid) begin
        check("r_pending", 32'(exp_r.size() != 0), 32'd1);
        check("rresp", 32'(rresp), 32'(RESP_OKAY));
        if (exp_r.size() != 0) check("rdata", rdata, exp_r.pop_front());
      end
      if (prev_stall && !allow_drop) check("tvalid_hold", 32'(tvalid), 32'd1);
      if (tvalid && !allow_drop) begin
        check("s_pending", 32'(exp_s.size() != 0), 32'd1);
        if (exp_s.size() != 0) begin
          check("tdata", tdata, exp_s[0].data);
          check("tlast", 32'(tlast), 32'(exp_s[0].last));
          if (tready) void'(exp_s.pop_front());
        end
      end
      if (tvalid && tready) hs_count++;
      prev_stall = tvalid && !tready;
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp);
    bit seen = 1'b0;
    exp_b.push_back(resp);
    @(posedge clk);
    #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (awready && wready) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL aw_timeout: got no AWREADY/WREADY, expected within 20 cycles (addr 0x%h)", a);
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    bit seen = 1'b0;
    exp_r.push_back(exp);
    @(posedge clk);
    #1;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (arready) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL ar_timeout: got no ARREADY, expected within 20 cycles (addr 0x%h)", a);
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) axi_write(ADDR_DATA, base + 32'(i), 4'hF, RESP_OKAY);
  endtask

  task automatic expect_beats(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_s.push_back('{data: base + 32'(i), last: (i == n - 1)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion within 200 us");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;

    // 1. Reset
    #100;
    check("reset_axi_outs", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    check("reset_resp", {28'd0, bresp, rresp}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_stream", {tdata[30:0], tvalid} | {31'd0, tlast}, 32'd0);
    #100;
    rst_n = 1'b1;
    axi_read(ADDR_STATUS, 32'h0000_0008);
    check("idle_tvalid", 32'(tvalid), 32'd0);

    // 2. Basic run with TREADY held high
    tready = 1'b1;
    push_words(32'h1, 4);
    axi_write(ADDR_LEN, 32'd4, 4'hF, RESP_OKAY);
    expect_beats(32'h1, 4);
    h0 = hs_count;
    axi_write(ADDR_CTRL, 32'h1, 4'hF, RESP_OKAY);
    repeat (12) @(posedge clk);
    check("s2_handshakes", 32'(hs_count - h0), 32'd4);
    axi_read(ADDR_STATUS, 32'h0000_000A);

    // 3. Backpressure: TREADY toggles every cycle
    push_words(32'h11, 4);
    expect_beats(32'h11, 4);
    h0 = hs_count;
    tready = 1'b0;
    fork
      axi_write(ADDR_CTRL, 32'h1, 4'hF, RESP_OKAY);
      begin
        repeat (30) begin
          @(posedge clk);
          #1 tready = ~tready;
        end
      end
    join
    tready = 1'b1;
    repeat (4) @(posedge clk);
    check("s3_handshakes", 32'(hs_count - h0), 32'd4);
    axi_read(ADDR_STATUS, 32'h0000_000A);

    // 5. START with LEN > count is ignored, DONE kept
    push_words(32'h21, 4);
    axi_write(ADDR_LEN, 32'd5, 4'hF, RESP_OKAY);
    h0 = hs_count;
    axi_write(ADDR_CTRL, 32'h1, 4'hF, RESP_OKAY);
    repeat (4) @(posedge clk);
    check("s5_no_tvalid", 32'(tvalid), 32'd0);
    check("s5_handshakes", 32'(hs_count - h0), 32'd0);
    axi_read(ADDR_STATUS, 32'h0000_0402);

    // 6. CLEAR after two of four words
    axi_write(ADDR_LEN, 32'd4, 4'hF, RESP_OKAY);
    expect_beats(32'h21, 4);
    tready = 1'b0;
    h0 = hs_count;
    axi_write(ADDR_CTRL, 32'h1, 4'hF, RESP_OKAY);
    tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    tready = 1'b0;
    allow_drop = 1'b1;
    exp_s.delete();
    check("s6_handshakes", 32'(hs_count - h0), 32'd2);
    axi_write(ADDR_CTRL, 32'h2, 4'hF, RESP_OKAY);
    check("s6_tvalid_drop", 32'(tvalid), 32'd0);
    @(posedge clk);
    allow_drop = 1'b0;
    tready = 1'b1;
    axi_read(ADDR_STATUS, 32'h0000_0008);

    // 4. Overflow: 16 words fit, the 17th is refused
    push_words(32'h100, 16);
    axi_write(ADDR_DATA, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR);
    axi_read(ADDR_STATUS, 32'h0000_1004);
    axi_write(ADDR_LEN, 32'd16, 4'hF, RESP_OKAY);
    axi_write(ADDR_LEN, 32'h0000_00AB, 4'b1110, RESP_OKAY);
    axi_read(ADDR_LEN, 32'h0000_0010);
    axi_read(ADDR_CTRL, 32'h0000_0000);
    expect_beats(32'h100, 16);
    h0 = hs_count;
    axi_write(ADDR_CTRL, 32'h1, 4'hF, RESP_OKAY);
    repeat (30) @(posedge clk);
    check("s4_handshakes", 32'(hs_count - h0), 32'd16);
    axi_read(ADDR_STATUS, 32'h0000_000A);

    repeat (4) @(posedge clk);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    check("r_queue_drained", 32'(exp_r.size()), 32'd0);
    check("s_queue_drained", 32'(exp_s.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
